// File: rtl/serial_debug_node.sv
// Store-and-forward node on the serial debug ring. A frame is
// {dir, addr[14:0], data[BITS-1:0]}, sent MSB first. A write hit updates
// debug_out, a read hit replaces the payload with debug_in, and every frame
// is retransmitted downstream with the same framing.
module serial_debug_node #(
  parameter int          BITS      = 128,
  parameter logic [14:0] NODE_ADDR = 15'h0001,
  parameter bit          ENABLE    = 1'b1,
  parameter int          TIMEOUT   = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      prescaler,
  input  logic            debug_rx_data,
  input  logic            debug_rx_clk,
  output logic            debug_tx_data,
  output logic            debug_tx_clk,
  input  logic [BITS-1:0] debug_in,
  output logic [BITS-1:0] debug_out,
  output logic            debug_out_valid,
  output logic            rx_overrun
);

  localparam int SF_BITS = BITS + 16;
  localparam int CW      = $clog2(SF_BITS + 1);
  localparam int IW      = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] SF_LAST   = CW'(SF_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  generate
    if (ENABLE) begin : g_node
      typedef enum logic [1:0] {
        RX   = 2'd0,
        PROC = 2'd1,
        TX   = 2'd2
      } state_t;

      state_t             state;
      logic [SF_BITS-1:0] frame;
      logic [CW-1:0]      bit_cnt;
      logic [IW-1:0]      idle_cnt;
      logic [7:0]         hp_cnt;
      logic [7:0]         hp_load;
      logic               clk_s1, clk_s2, clk_h;
      logic               dat_s1, dat_s2;
      logic               rx_rise;
      logic               frame_dir;
      logic [14:0]        frame_addr;

      // Two-flop synchronisers plus a history flop on the rx clock
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          clk_s1 <= 1'b1;
          clk_s2 <= 1'b1;
          clk_h  <= 1'b1;
          dat_s1 <= 1'b0;
          dat_s2 <= 1'b0;
        end else begin
          clk_s1 <= debug_rx_clk;
          clk_s2 <= clk_s1;
          clk_h  <= clk_s2;
          dat_s1 <= debug_rx_data;
          dat_s2 <= dat_s1;
        end
      end

      // Edge detect, header decode and effective half-period
      always_comb begin
        rx_rise    = clk_s2 & ~clk_h;
        frame_dir  = frame[SF_BITS-1];
        frame_addr = frame[SF_BITS-2:BITS];
        hp_load    = (prescaler == 8'd0) ? 8'd1 : prescaler;
      end

      // Receive / process / transmit sequencer with registered outputs
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state           <= RX;
          frame           <= '0;
          bit_cnt         <= '0;
          idle_cnt        <= '0;
          hp_cnt          <= '0;
          debug_tx_clk    <= 1'b1;
          debug_tx_data   <= 1'b0;
          debug_out       <= '0;
          debug_out_valid <= 1'b0;
          rx_overrun      <= 1'b0;
        end else begin
          debug_out_valid <= 1'b0;
          case (state)
            RX: begin
              if (rx_rise) begin
                frame    <= {frame[SF_BITS-2:0], dat_s2};
                idle_cnt <= '0;
                if (bit_cnt == SF_LAST) begin
                  bit_cnt <= '0;
                  state   <= PROC;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end else if (bit_cnt != '0) begin
                // Abandon a stalled partial frame silently
                if (idle_cnt == IDLE_LAST) begin
                  bit_cnt  <= '0;
                  idle_cnt <= '0;
                end else begin
                  idle_cnt <= idle_cnt + 1'b1;
                end
              end else begin
                idle_cnt <= '0;
              end
            end
            PROC: begin
              if (rx_rise) rx_overrun <= 1'b1;
              if (frame_addr == NODE_ADDR) begin
                if (frame_dir) begin
                  debug_out       <= frame[BITS-1:0];
                  debug_out_valid <= 1'b1;
                end else begin
                  frame[BITS-1:0] <= debug_in;
                end
              end
              hp_cnt       <= hp_load;
              debug_tx_clk <= 1'b1;
              state        <= TX;
            end
            TX: begin
              if (rx_rise) rx_overrun <= 1'b1;
              if (hp_cnt <= 8'd1) begin
                hp_cnt <= hp_load;
                if (debug_tx_clk) begin
                  debug_tx_data <= frame[SF_BITS-1];
                  frame         <= {frame[SF_BITS-2:0], 1'b0};
                  debug_tx_clk  <= 1'b0;
                end else begin
                  debug_tx_clk <= 1'b1;
                  if (bit_cnt == SF_LAST) begin
                    bit_cnt <= '0;
                    state   <= RX;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
              end else begin
                hp_cnt <= hp_cnt - 1'b1;
              end
            end
            default: state <= RX;
          endcase
        end
      end
    end else begin : g_wire
      // Disabled node: one-flop pass-through of the ring
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          debug_tx_data <= 1'b0;
          debug_tx_clk  <= 1'b1;
        end else begin
          debug_tx_data <= debug_rx_data;
          debug_tx_clk  <= debug_rx_clk;
        end
      end

      assign debug_out       = '0;
      assign debug_out_valid = 1'b0;
      assign rx_overrun      = 1'b0;
    end
  endgenerate

endmodule
